msb_scan_seq: RTL and testbench



---
 rtl/msb_scan_seq.sv | 125 ++++++++++++
 tb/tb_msb_scan_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/msb_scan_seq.sv
// msb_scan_seq: sequential MSB/LSB finder that scans one CHUNK-bit slice per
// clock between a valid/ready producer and a valid/ready consumer. The scan
// stops early at the first non-zero slice.
module msb_scan_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned POS_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero
);

    localparam int unsigned NS    = N / CHUNK;
    localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned PW    = $clog2(CHUNK + 1);

    // Reject parameter sets the slice arithmetic cannot handle
    if ((N % CHUNK) != 0) begin : g_bad_n
        $error("msb_scan_seq: N must be a multiple of CHUNK");
    end
    if ((CHUNK < 2) || ((CHUNK & (CHUNK - 1)) != 0)) begin : g_bad_chunk
        $error("msb_scan_seq: CHUNK must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [N-1:0]       data;
    logic               mode;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   slice_c;
    logic [PW-1:0]      p_c;
    logic               last_c;
    logic [POS_W-1:0]   pos_c;

    // Single-slice priority encoder: 1-based highest (mode 0) or lowest (mode 1) set bit
    always_comb begin
        slice_c = data[idx*CHUNK +: CHUNK];
        p_c     = '0;
        if (!mode) begin
            for (int i = 0; i < int'(CHUNK); i++) begin
                if (slice_c[i]) p_c = PW'(i + 1);
            end
        end else begin
            for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
                if (slice_c[i]) p_c = PW'(i + 1);
            end
        end
        last_c = mode ? (idx == IDX_W'(NS - 1)) : (idx == '0);
        pos_c  = POS_W'(int'(idx) * int'(CHUNK) + int'(p_c));
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_zero  <= 1'b0;
            data      <= '0;
            mode      <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        data     <= in_data;
                        mode     <= in_mode;
                        idx      <= in_mode ? '0 : IDX_W'(NS - 1);
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    in_ready <= 1'b0;
                    if (slice_c != '0) begin
                        out_pos   <= pos_c;
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (last_c) begin
                        out_pos   <= '0;
                        out_zero  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (mode) begin
                        idx <= idx + 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msb_scan_seq.sv
// Directed self-checking bench for msb_scan_seq with N=32, CHUNK=8.
module tb_msb_scan_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_pos;
    logic        out_zero;

    int checks   = 0;
    int failures = 0;

    msb_scan_seq #(.N(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word, return edges to out_valid (-1 on timeout) and the result
    task automatic do_txn(input logic [31:0] d, input logic m,
                          output int lat, output logic [5:0] pos, output logic z);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_mode  = ~m;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        pos = out_pos;
        z   = out_zero;
    endtask

    // Complete the output handshake
    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_pos !== 6'd0) begin failures++; $display("FAIL reset_out_pos got=%0d exp=0", out_pos); end
        checks++;
        if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    // Directed vectors: data, mode, expected latency, position, zero flag
    task automatic test_vectors();
        logic [31:0] vd [8];
        logic        vm [8];
        int          vl [8];
        logic [5:0]  vp [8];
        logic        vz [8];
        int          lat;
        logic [5:0]  pos;
        logic        z;
        vd[0] = 32'h8000_0000; vm[0] = 1'b0; vl[0] = 1; vp[0] = 6'd32; vz[0] = 1'b0;
        vd[1] = 32'h0000_0001; vm[1] = 1'b0; vl[1] = 4; vp[1] = 6'd1;  vz[1] = 1'b0;
        vd[2] = 32'h0000_0001; vm[2] = 1'b1; vl[2] = 1; vp[2] = 6'd1;  vz[2] = 1'b0;
        vd[3] = 32'h0000_0000; vm[3] = 1'b0; vl[3] = 4; vp[3] = 6'd0;  vz[3] = 1'b1;
        vd[4] = 32'h0000_0000; vm[4] = 1'b1; vl[4] = 4; vp[4] = 6'd0;  vz[4] = 1'b1;
        vd[5] = 32'h0001_0100; vm[5] = 1'b0; vl[5] = 2; vp[5] = 6'd17; vz[5] = 1'b0;
        vd[6] = 32'h0001_0100; vm[6] = 1'b1; vl[6] = 2; vp[6] = 6'd9;  vz[6] = 1'b0;
        vd[7] = 32'h8000_0000; vm[7] = 1'b1; vl[7] = 4; vp[7] = 6'd32; vz[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_txn(vd[i], vm[i], lat, pos, z);
            checks++;
            if (lat !== vl[i]) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
            checks++;
            if (pos !== vp[i]) begin failures++; $display("FAIL vec%0d_pos got=%0d exp=%0d", i, pos, vp[i]); end
            checks++;
            if (z !== vz[i]) begin failures++; $display("FAIL vec%0d_zero got=%b exp=%b", i, z, vz[i]); end
            release_out();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_valid_drop got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [5:0]  pos;
        logic        z;
        do_txn(32'h0000_00F0, 1'b0, lat, pos, z);
        checks++;
        if (lat !== 4 || pos !== 6'd8) begin failures++; $display("FAIL bp_first got lat=%0d pos=%0d exp lat=4 pos=8", lat, pos); end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_0004;
        in_mode  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pos !== 6'd8 || out_zero !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b pos=%0d z=%b rdy=%b exp v=1 pos=8 z=0 rdy=0",
                         c, out_valid, out_pos, out_zero, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (lat !== 1 || out_pos !== 6'd3 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL bp_second got lat=%0d pos=%0d z=%b exp lat=1 pos=3 z=0", lat, out_pos, out_zero);
        end
        release_out();
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        @(negedge clk);
        in_data  = 32'h0000_0001;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pos !== 6'd0 || out_zero !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_scan got v=%b pos=%0d z=%b rdy=%b exp v=0 pos=0 z=0 rdy=0",
                     out_valid, out_pos, out_zero, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_scan_ready got=%b exp=1", in_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rst_scan_stale got=%0d valid cycles exp=0", seen); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
